if_id_queue: RTL and testbench

- Fetch-to-decode buffer placed directly downstream of the PC/instruction-fetch stage.
- Captures each {pc, inst} pair that fetch produces and holds it in a small in-order FIFO.
- Presents the oldest pair to the decode stage through a valid/ready handshake.
- Absorbs decode stalls and discards all buffered instructions when a jump redirect (flush) occurs.

---
 rtl/if_id_queue.sv | 74 +++++++
 tb/tb_if_id_queue.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: in-order FIFO of {pc, inst} pairs with valid/ready on both sides.
// Flush and reset invalidate everything through the pointers and occupancy; storage itself is never cleared.
module if_id_queue #(
  parameter int unsigned          DEPTH    = 2,
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter logic [INST_W-1:0]    NOP_INST = 32'h00000013
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         if_pc,
  input  logic [INST_W-1:0]         if_inst,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic                      flush,
  output logic [ADDR_W-1:0]         id_pc,
  output logic [INST_W-1:0]         id_inst,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Both handshakes depend only on registered occupancy, so id_ready never reaches if_ready.
  assign w_push = if_valid && !w_full  && !flush;
  assign w_pop  = id_ready && !w_empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_pc_mem[r_wr_ptr]   <= if_pc;
      r_inst_mem[r_wr_ptr] <= if_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Empty queue presents a NOP so stale or X storage never leaks to decode.
  assign if_ready = !w_full;
  assign id_valid = !w_empty;
  assign id_pc    = w_empty ? '0       : r_pc_mem[r_rd_ptr];
  assign id_inst  = w_empty ? NOP_INST : r_inst_mem[r_rd_ptr];
  assign count    = r_count;

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed test-plan sequences followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic        flush = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [$clog2(DEPTH):0] count;

  if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .if_ready(if_ready),
    .flush(flush),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .id_ready(id_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t model_q[$];
  int     n_pass  = 0;
  int     n_total = 0;
  bit     checking = 0;
  bit     done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: compare DUT outputs with the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    entry_t e;
    bit     do_push;
    bit     do_pop;
    if (checking && !done) begin
      chk("count", 64'(count), 64'(model_q.size()));
      chk("if_ready", 64'(if_ready), 64'(model_q.size() != DEPTH));
      chk("id_valid", 64'(id_valid), 64'(model_q.size() != 0));
      chk("id_pc", 64'(id_pc), (model_q.size() != 0) ? 64'(model_q[0].pc) : 64'd0);
      chk("id_inst", 64'(id_inst), (model_q.size() != 0) ? 64'(model_q[0].inst) : 64'(NOP));
      chk("count_bound", 64'(count <= DEPTH), 64'd1);
    end
    if (rst) begin
      model_q.delete();
      checking = 1;
    end else if (flush) begin
      model_q.delete();
    end else begin
      do_push = if_valid && (model_q.size() < DEPTH);
      do_pop  = id_ready && (model_q.size() > 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.pc   = if_pc;
        e.inst = if_inst;
        model_q.push_back(e);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl, input bit r);
    @(posedge clk);
    #2;
    rst = r; if_valid = v; if_pc = pc; if_inst = inst; id_ready = rdy; flush = fl;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 32'hdead_beef, 32'hbad0_0bad, rdy, 0, 0);
  endtask

  initial begin
    int  pc_next;
    int  k;
    bit  pat [5] = '{1, 0, 1, 1, 0};

    // reset held two cycles with fetch offering a beat
    rst = 1; if_valid = 1; if_pc = 32'h40; if_inst = 32'h1111_1111;
    drive(1, 32'h40, 32'h1111_1111, 0, 0, 1);
    idle(0);

    // single beat
    drive(1, 32'h0, 32'h0010_0093, 0, 0, 0);
    idle(0);
    idle(1);
    idle(0);

    // fill and backpressure, third beat refused
    drive(1, 32'h0, 32'hA000_0000, 0, 0, 0);
    drive(1, 32'h4, 32'hA000_0004, 0, 0, 0);
    drive(1, 32'h8, 32'hA000_0008, 0, 0, 0);
    idle(1);
    idle(0);
    idle(1);
    idle(1);

    // simultaneous push/pop at count=1
    drive(1, 32'h10, 32'hB000_0010, 0, 0, 0);
    drive(1, 32'h14, 32'hB000_0014, 1, 0, 0);
    idle(0);
    idle(1);
    idle(0);

    // wrap-around stream of 7 beats with toggling decode ready
    pc_next = 0;
    k = 0;
    while (pc_next <= 32'h18 && k < 60) begin
      drive(1, 32'(pc_next), 32'hC000_0000 | 32'(pc_next), pat[k % 5], 0, 0);
      k++;
      #1;
      if (if_ready) pc_next += 4;
    end
    if (k >= 60) begin
      n_total++;
      $display("FAIL wrap_timeout: got %0d beats expected 7", pc_next / 4);
    end
    for (int i = 0; i < 4; i++) idle(1);

    // flush with a concurrent offer and pop, then recovery
    drive(1, 32'h20, 32'hD000_0020, 0, 0, 0);
    drive(1, 32'h24, 32'hD000_0024, 0, 0, 0);
    drive(1, 32'h28, 32'hD000_0028, 1, 1, 0);
    drive(1, 32'h80, 32'hD000_0080, 0, 0, 0);
    idle(0);
    idle(1);

    // flush while empty, consecutive flushes, reset mid-operation
    drive(1, 32'h30, 32'hE000_0030, 1, 1, 0);
    drive(1, 32'h34, 32'hE000_0034, 1, 1, 0);
    drive(1, 32'h38, 32'hE000_0038, 0, 0, 0);
    drive(1, 32'h3c, 32'hE000_003c, 0, 0, 1);
    idle(0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 24) == 0, $urandom_range(0, 99) == 0);
    end
    idle(1);
    idle(1);
    idle(0);

    @(posedge clk);
    #1;
    done = 1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
